eth_phy_10g_tx_gearbox: RTL
===========================

Name: eth_phy_10g_tx_gearbox

Overview:
66:64 transmit gearbox for the 10G Ethernet PHY. It sits between the TX 64b/66b encoder/scrambler and the SERDES, which carries 64 bits per clock. It packs 2-bit sync header + 64-bit payload blocks into a continuous 64-bit word stream and pauses the upstream one cycle in every 33. It is the transmit-side counterpart of the RX block-lock/bit-slip aligner; its output stream must achieve lock on that aligner.

Parameters:
HDR_WIDTH, 2, sync header width; only 2 supported.
DATA_WIDTH, 64, block payload and SERDES word width; only 64 supported.
IDLE_INSERT, 1, 1 = substitute an idle control block when upstream is not valid on an accept cycle; 0 = send the input as presented.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
i_tx_hdr  input  HDR_WIDTH  sync header of input block; 2'b01 = control, 2'b10 = data
i_tx_data  input  DATA_WIDTH  scrambled block payload
i_tx_valid  input  1  input block is valid
o_tx_ready  output  1  input consumed this cycle when high (pause when low)
o_serdes_tx_data  output  DATA_WIDTH  word to SERDES; bit 0 transmitted first
o_underflow  output  1  one-cycle pulse: idle block was inserted
o_seq  output  6  current sequence counter value (0..32), for debug

Behaviour:
- Wire order: block bit 0 = hdr[0], bit 1 = hdr[1], bits 2..65 = data[0..63]. Form a 66-bit vector blk = {data, hdr}.
- State:
  - seq_reg: 6 bits, 0..32.
  - buf_reg: 128-bit residue buffer.
  - cnt_reg: residue bit count, 0..64, always even.
- o_tx_ready = !rst && (seq_reg != 32). It is combinational from the register.
- Accept cycle (seq_reg 0..31), in order:
  - blk_eff = blk if i_tx_valid or IDLE_INSERT = 0; otherwise the idle block {64'h000000000000001E, 2'b01}.
  - tmp = buf_reg | (blk_eff << cnt_reg).
  - o_serdes_tx_data <= tmp[63:0].
  - buf_reg <= tmp >> 64.
  - cnt_reg <= cnt_reg + 2.
  - seq_reg <= seq_reg + 1.
- Pause cycle (seq_reg == 32):
  - Input is ignored.
  - cnt_reg is 64 here by construction.
  - o_serdes_tx_data <= buf_reg[63:0]; buf_reg <= 0; cnt_reg <= 0; seq_reg <= 0.
- Latency: 1 cycle. The word containing a block's first bit is registered on the clock edge that accepts the block.
- o_underflow <= 1 on an accept cycle with i_tx_valid = 0 and IDLE_INSERT = 1; 0 otherwise. It is never asserted on a pause cycle.
- Period: exactly 32 accepts + 1 pause per 33 cycles. This equals 2112 bits in and 2112 bits out; there is no drift and no overflow.
- Reset: the following values are held while rst is high. Reset mid-period discards the residue; after rst deasserts the sequence restarts at 0.
  - seq_reg = 0, cnt_reg = 0, buf_reg = 0.
  - o_serdes_tx_data = 0, o_underflow = 0, o_tx_ready = 0, o_seq = 0.
- i_tx_valid has no effect on the pause schedule. The upstream must not hold a block across a pause; it re-presents it on the next ready cycle.
- Headers are not checked: invalid headers (00/11) are passed through unchanged, so RX-aligner slip behaviour can be tested.

Test Plan:
1. Release rst, hold i_tx_valid = 1 continuously → o_tx_ready low on exactly cycles 32, 65, 98… after release; o_seq counts 0..32 and wraps to 0.
2. Present blocks B0 = {64'h0123456789ABCDEF, 2'b10} and B1 = {64'hFEDCBA9876543210, 2'b01} on the first two cycles:
   - word0 = {B0.data[61:0], 2'b10}.
   - word1 = {B1.data[59:0], 2'b01, B0.data[63:62]}.
3. Send 32 blocks with random payloads; the bench concatenates 33 output words into a 2112-bit stream and splits it at 66-bit boundaries → all 32 blocks are recovered exactly. The pause-cycle word = {B31.data[63:0]}.
4. Drop i_tx_valid on accept cycle 5 with IDLE_INSERT = 1 → the recovered block 5 is {64'h1E, 2'b01}, o_underflow pulses once, and the next pause stays at cycle 32. With IDLE_INSERT = 0 the raw input is used and o_underflow stays 0.
5. Assert rst at seq = 17 for 3 cycles → all outputs 0 during reset. After release, o_seq restarts at 0, the first word = {next.data[61:0], hdr}, and the first pause is 32 cycles later.
6. Loopback through a bench-side 64→66 slip model into the RX aligner, with a random initial bit offset 0..65 and valid headers → the aligner asserts aligned, and recovered blocks match the sent blocks with no header errors after lock.

Source files
------------

// File: rtl/eth_phy_10g_tx_gearbox_if.sv
// Upstream block stream and SERDES-side word stream of the 10G TX gearbox.
interface eth_phy_10g_tx_gearbox_if #(
  parameter int HDR_WIDTH  = 2,
  parameter int DATA_WIDTH = 64
);
  logic [HDR_WIDTH-1:0]  i_tx_hdr;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_serdes_tx_data;
  logic                  o_underflow;
  logic [5:0]            o_seq;

  modport master (
    output i_tx_hdr, i_tx_data, i_tx_valid,
    input  o_tx_ready, o_serdes_tx_data, o_underflow, o_seq
  );
  modport slave (
    input  i_tx_hdr, i_tx_data, i_tx_valid,
    output o_tx_ready, o_serdes_tx_data, o_underflow, o_seq
  );
endinterface

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66:64 TX gearbox: packs {data,hdr} blocks into a continuous 64-bit word stream,
// pausing upstream once every 33 cycles to absorb the 2 extra header bits per block.
module eth_phy_10g_tx_gearbox #(
  parameter int HDR_WIDTH   = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int IDLE_INSERT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  eth_phy_10g_tx_gearbox_if.slave   tx
);
  localparam int BLK_W = HDR_WIDTH + DATA_WIDTH;
  localparam int BUF_W = 2 * DATA_WIDTH;
  localparam logic [5:0] PAUSE_SEQ = 6'd32;
  localparam logic [BLK_W-1:0] IDLE_BLK = {{(DATA_WIDTH-8){1'b0}}, 8'h1E, 2'b01};

  logic [5:0]            seq_q, seq_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  uf_q, uf_d;

  logic [BLK_W-1:0]      blk_eff;
  logic [BUF_W-1:0]      tmp;
  logic                  ins_idle;

  assign ins_idle = !tx.i_tx_valid && (IDLE_INSERT != 0);
  assign blk_eff  = ins_idle ? IDLE_BLK : {tx.i_tx_data, tx.i_tx_hdr};
  assign tmp      = buf_q | ({{(BUF_W-BLK_W){1'b0}}, blk_eff} << cnt_q);

  always_comb begin
    seq_d  = seq_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    uf_d   = 1'b0;
    if (seq_q == PAUSE_SEQ) begin
      // residue holds exactly one full word here; flush it and restart
      data_d = buf_q[DATA_WIDTH-1:0];
      buf_d  = '0;
      cnt_d  = '0;
      seq_d  = '0;
    end else begin
      data_d = tmp[DATA_WIDTH-1:0];
      buf_d  = tmp >> DATA_WIDTH;
      cnt_d  = cnt_q + 7'd2;
      seq_d  = seq_q + 6'd1;
      uf_d   = ins_idle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q  <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      uf_q   <= uf_d;
    end
  end

  assign tx.o_tx_ready       = !rst && (seq_q != PAUSE_SEQ);
  assign tx.o_serdes_tx_data = data_q;
  assign tx.o_underflow      = uf_q;
  assign tx.o_seq            = seq_q;
endmodule
